// File: rtl/cronometro_pkg.sv
// Shared types and constants for the stopwatch controller: FSM/mode enums,
// BCD time representation, 7-segment codes and the BCD +/-1 helper.
package cronometro_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    MODE_UP        = 2'b00,
    MODE_DOWN      = 2'b01,
    MODE_CLEAR     = 2'b10,
    MODE_CLEAR_ALT = 2'b11
  } mode_e;

  typedef logic [3:0] bcd_t;

  // Digit 0 = centisecond units ... digit 5 = minute tens.
  typedef bcd_t [5:0] bcd_time_t;

  localparam bcd_time_t DIGIT_MAX = {4'd5, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9};
  localparam bcd_time_t TIME_ZERO = '0;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // One centisecond up or down, rippling carry/borrow through every digit.
  function automatic bcd_time_t bcd_step(input bcd_time_t t, input logic down);
    bcd_time_t r;
    logic carry;
    r = t;
    carry = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (carry) begin
        if (down) begin
          if (t[i] == 4'd0) begin
            r[i] = DIGIT_MAX[i];
          end else begin
            r[i] = t[i] - 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (t[i] == DIGIT_MAX[i]) begin
            r[i] = 4'd0;
          end else begin
            r[i] = t[i] + 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/cronometro_ctrl_seg7.sv
// BCD digit to active-low 7-segment pattern {g..a}; non-BCD codes blank.
module seg7_decoder
  import cronometro_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/cronometro_ctrl.sv
// Stopwatch / countdown controller: input sync + debounce, 10 ms prescaler,
// MM:SS.cc BCD counter, run/pause/done FSM and registered 7-seg/LED outputs.
module cronometro_ctrl
  import cronometro_pkg::*;
#(
  parameter int TICK_DIV   = 500000,
  parameter int DEB_CYCLES = 500000,
  parameter int PRESET_MIN = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       switch_mode0,
  input  logic       switch_mode1,
  input  logic       switch_pause,
  input  logic       play_btn,
  output logic [6:0] disp0,
  output logic [6:0] disp1,
  output logic [6:0] disp2,
  output logic [6:0] disp3,
  output logic [6:0] disp4,
  output logic [6:0] disp5,
  output logic [2:0] leds
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam bcd_t      PRESET_TENS  = bcd_t'(PRESET_MIN / 10);
  localparam bcd_t      PRESET_UNITS = bcd_t'(PRESET_MIN % 10);
  localparam bcd_time_t PRESET_TIME  = {PRESET_TENS, PRESET_UNITS, 16'h0000};
  // Synchronizer bit order {play_btn, switch_pause, mode1, mode0}; button idles high.
  localparam logic [3:0] SYNC_RESET = 4'b1000;

  logic [3:0]        sync1_q, sync1_d, sync2_q, sync2_d;
  logic              deb_level_q, deb_level_d;
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic              press_q, press_d;
  mode_e             mode_q, mode_d;
  logic [TICK_W-1:0] presc_q, presc_d;
  state_e            state_q, state_d;
  bcd_time_t         count_q, count_d;
  logic [5:0][6:0]   disp_q, disp_d;
  logic [2:0]        leds_q, leds_d;

  mode_e     mode_sync;
  logic      pause_sync, btn_sync;
  logic      mode_change, mode_runnable, tick;
  bcd_time_t reload, count_step;
  logic [6:0] seg_w [6];

  assign mode_sync     = mode_e'(sync2_q[1:0]);
  assign pause_sync    = sync2_q[2];
  assign btn_sync      = sync2_q[3];
  assign mode_change   = (mode_sync != mode_q);
  assign mode_runnable = (mode_sync == MODE_UP) || (mode_sync == MODE_DOWN);
  assign reload        = (mode_sync == MODE_DOWN) ? PRESET_TIME : TIME_ZERO;
  assign tick          = (state_q == ST_RUN) && (presc_q == TICK_LAST);
  assign count_step    = bcd_step(count_q, mode_q == MODE_DOWN);

  always_comb begin
    sync1_d = {play_btn, switch_pause, switch_mode1, switch_mode0};
    sync2_d = sync1_q;
    mode_d  = mode_sync;
  end

  // A level change is accepted only after it has persisted DEB_CYCLES cycles.
  always_comb begin
    deb_level_d = deb_level_q;
    deb_cnt_d   = '0;
    press_d     = 1'b0;
    if (btn_sync != deb_level_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        deb_level_d = btn_sync;
        press_d     = ~btn_sync;
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
    end
  end

  always_comb begin
    presc_d = '0;
    case (state_q)
      ST_RUN:   presc_d = tick ? '0 : presc_q + TICK_W'(1);
      ST_PAUSE: presc_d = presc_q;
      default:  presc_d = '0;
    endcase
  end

  // A mode change outranks everything else, including a same-cycle tick.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (mode_change) begin
      state_d = ST_IDLE;
      count_d = reload;
    end else begin
      case (state_q)
        ST_IDLE: begin
          count_d = reload;
          if (press_q && mode_runnable) begin
            state_d = (mode_sync == MODE_DOWN && PRESET_MIN == 0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (pause_sync || press_q) begin
            state_d = ST_PAUSE;
          end else if (tick) begin
            count_d = count_step;
            if (mode_q == MODE_DOWN && count_step == TIME_ZERO) begin
              state_d = ST_DONE;
            end
          end
        end
        ST_PAUSE: begin
          if (press_q && !pause_sync) begin
            state_d = ST_RUN;
          end
        end
        ST_DONE: begin
          count_d = TIME_ZERO;
          if (press_q) begin
            state_d = ST_IDLE;
            count_d = reload;
          end
        end
        default: begin
          state_d = ST_IDLE;
          count_d = reload;
        end
      endcase
    end
  end

  for (genvar g = 0; g < 6; g++) begin : g_seg
    seg7_decoder u_dec (
      .bcd (count_q[g]),
      .seg (seg_w[g])
    );
  end

  always_comb begin
    disp_d = '0;
    for (int i = 0; i < 6; i++) begin
      disp_d[i] = seg_w[i];
    end
    leds_d = {state_q == ST_DONE, state_q == ST_PAUSE, state_q == ST_RUN};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q     <= SYNC_RESET;
      sync2_q     <= SYNC_RESET;
      deb_level_q <= 1'b1;
      deb_cnt_q   <= '0;
      press_q     <= 1'b0;
      mode_q      <= MODE_UP;
      presc_q     <= '0;
      state_q     <= ST_IDLE;
      count_q     <= TIME_ZERO;
      disp_q      <= {6{SEG_0}};
      leds_q      <= 3'b000;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      deb_level_q <= deb_level_d;
      deb_cnt_q   <= deb_cnt_d;
      press_q     <= press_d;
      mode_q      <= mode_d;
      presc_q     <= presc_d;
      state_q     <= state_d;
      count_q     <= count_d;
      disp_q      <= disp_d;
      leds_q      <= leds_d;
    end
  end

  assign disp0 = disp_q[0];
  assign disp1 = disp_q[1];
  assign disp2 = disp_q[2];
  assign disp3 = disp_q[3];
  assign disp4 = disp_q[4];
  assign disp5 = disp_q[5];
  assign leds  = leds_q;

endmodule

// File: tb/tb_cronometro_ctrl.sv
// Directed + randomized bench for cronometro_ctrl; every cycle the outputs are
// compared with a centisecond-integer reference model of the stopwatch.
module tb_cronometro_ctrl;

  localparam int TICK_DIV   = 4;
  localparam int DEB_CYCLES = 2;
  localparam int PRESET_MIN = 1;
  localparam int FULL_SCALE = 360000;

  logic clk, reset;
  logic switchMode0, switchMode1, switchPause, playBtn;
  logic [6:0] disp0, disp1, disp2, disp3, disp4, disp5;
  logic [2:0] leds;
  logic [41:0] obsDisp;

  int vectors = 0;
  int miscompares = 0;

  typedef enum {M_IDLE, M_RUN, M_PAUSE, M_DONE} mstate_t;
  mstate_t    mState;
  int         mCs, mPresc, mRun, expDispCs;
  logic       mDeb, mPress;
  logic [1:0] mModePrev;
  logic [2:0] expLeds;
  logic [3:0] syncLine [$];

  logic [6:0] s0, s1;

  cronometro_ctrl #(
    .TICK_DIV   (TICK_DIV),
    .DEB_CYCLES (DEB_CYCLES),
    .PRESET_MIN (PRESET_MIN)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .switch_mode0 (switchMode0),
    .switch_mode1 (switchMode1),
    .switch_pause (switchPause),
    .play_btn     (playBtn),
    .disp0        (disp0),
    .disp1        (disp1),
    .disp2        (disp2),
    .disp3        (disp3),
    .disp4        (disp4),
    .disp5        (disp5),
    .leds         (leds)
  );

  assign obsDisp = {disp5, disp4, disp3, disp2, disp1, disp0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] segOf(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [41:0] expDisp(input int cs);
    int mm, ss, cc;
    mm = cs / 6000;
    ss = (cs / 100) % 60;
    cc = cs % 100;
    return {segOf(mm / 10), segOf(mm % 10), segOf(ss / 10), segOf(ss % 10),
            segOf(cc / 10), segOf(cc % 10)};
  endfunction

  task automatic checkOutput(input string tag, input logic [41:0] observed,
                             input logic [41:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Reference model: time is an integer count of centiseconds; inputs reach
  // the controller through a two-deep delay line, then the debounce rule.
  task automatic modelStep();
    logic [3:0] s;
    logic [1:0] modeS;
    logic pauseS, btnS, tickNow, nPress;
    int reload, nCs;
    mstate_t nState;
    if (!reset) begin
      syncLine = '{4'b1000, 4'b1000};
      mDeb = 1'b1; mRun = 0; mPress = 1'b0; mModePrev = 2'b00; mPresc = 0;
      mState = M_IDLE; mCs = 0; expLeds = 3'b000; expDispCs = 0;
    end else begin
      s = syncLine[0];
      modeS = s[1:0];
      pauseS = s[2];
      btnS = s[3];
      expLeds = {mState == M_DONE, mState == M_PAUSE, mState == M_RUN};
      expDispCs = mCs;
      tickNow = (mState == M_RUN) && (mPresc == TICK_DIV - 1);
      reload = (modeS == 2'b01) ? PRESET_MIN * 6000 : 0;
      nState = mState;
      nCs = mCs;
      if (modeS != mModePrev) begin
        nState = M_IDLE;
        nCs = reload;
      end else begin
        case (mState)
          M_IDLE: begin
            nCs = reload;
            if (mPress && !modeS[1])
              nState = (modeS == 2'b01 && PRESET_MIN == 0) ? M_DONE : M_RUN;
          end
          M_RUN: begin
            if (pauseS || mPress) nState = M_PAUSE;
            else if (tickNow) begin
              if (modeS == 2'b00) nCs = (mCs + 1) % FULL_SCALE;
              else begin
                nCs = mCs - 1;
                if (nCs == 0) nState = M_DONE;
              end
            end
          end
          M_PAUSE: if (mPress && !pauseS) nState = M_RUN;
          M_DONE: begin
            nCs = 0;
            if (mPress) begin
              nState = M_IDLE;
              nCs = reload;
            end
          end
        endcase
      end
      mPresc = (mState == M_RUN) ? (mPresc + 1) % TICK_DIV :
               (mState == M_PAUSE) ? mPresc : 0;
      nPress = 1'b0;
      if (btnS != mDeb) begin
        mRun++;
        if (mRun == DEB_CYCLES) begin
          mDeb = btnS;
          mRun = 0;
          nPress = !btnS;
        end
      end else begin
        mRun = 0;
      end
      mPress = nPress;
      mModePrev = modeS;
      mState = nState;
      mCs = nCs;
      void'(syncLine.pop_front());
      syncLine.push_back({playBtn, switchPause, switchMode1, switchMode0});
    end
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic applyStimulus();
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkOutput("cyc_leds", 42'(leds), 42'(expLeds));
    checkOutput("cyc_disp", obsDisp, expDisp(expDispCs));
  endtask

  task automatic waitLeds(input logic [2:0] target, input int budget, input string tag);
    int n;
    n = 0;
    while (leds !== target && n < budget) begin
      applyStimulus();
      n++;
    end
    checkOutput(tag, 42'(leds), 42'(target));
  endtask

  initial begin
    int n;
    s0 = 7'b1000000;
    s1 = 7'b1111001;
    reset = 1'b0;
    playBtn = 1'b1;
    switchPause = 1'b0;
    switchMode0 = 1'b0;
    switchMode1 = 1'b0;
    $display("[TB] cronometro_ctrl bench start");

    repeat (3) applyStimulus();
    checkOutput("rst_leds", 42'(leds), 42'(3'b000));
    checkOutput("rst_disp", obsDisp, {6{s0}});
    reset = 1'b1;
    repeat (5) applyStimulus();

    // Count up for one second.
    playBtn = 1'b0;
    waitLeds(3'b001, 40, "up_run");
    playBtn = 1'b1;
    repeat (400) applyStimulus();
    checkOutput("up_1s_disp", obsDisp, {s0, s0, s0, s1, s0, s0});
    checkOutput("up_1s_leds", 42'(leds), 42'(3'b001));

    // Preload near full scale and watch it wrap.
    force dut.count_q = 24'h595998;
    #1 release dut.count_q;
    mCs = FULL_SCALE - 2;
    n = 0;
    while (mCs != 0 && n < 20) begin
      applyStimulus();
      n++;
    end
    applyStimulus();
    checkOutput("wrap_disp", obsDisp, {6{s0}});
    checkOutput("wrap_leds", 42'(leds), 42'(3'b001));

    // Pause hold, then resume with a press.
    switchPause = 1'b1;
    repeat (40) applyStimulus();
    checkOutput("pause_leds", 42'(leds), 42'(3'b010));
    switchPause = 1'b0;
    repeat (5) applyStimulus();
    checkOutput("pause_hold_leds", 42'(leds), 42'(3'b010));
    playBtn = 1'b0;
    waitLeds(3'b001, 40, "resume_run");
    playBtn = 1'b1;
    repeat (10) applyStimulus();

    // Mode flip timed so it reaches the FSM on the same cycle as a tick.
    n = 0;
    while (!(mState == M_RUN && mPresc == 1) && n < 20) begin
      applyStimulus();
      n++;
    end
    switchMode0 = 1'b1;
    repeat (4) applyStimulus();
    checkOutput("modesw_leds", 42'(leds), 42'(3'b000));
    checkOutput("modesw_disp", obsDisp, {s0, s1, s0, s0, s0, s0});

    // Full countdown from the preset, then reload from DONE.
    playBtn = 1'b0;
    waitLeds(3'b001, 40, "down_run");
    playBtn = 1'b1;
    waitLeds(3'b100, 24100, "down_done");
    checkOutput("down_done_disp", obsDisp, {6{s0}});
    playBtn = 1'b0;
    waitLeds(3'b000, 40, "done_idle");
    playBtn = 1'b1;
    checkOutput("reload_disp", obsDisp, {s0, s1, s0, s0, s0, s0});
    repeat (8) applyStimulus();

    // Single-cycle button glitch must not start the clock.
    playBtn = 1'b0;
    applyStimulus();
    playBtn = 1'b1;
    repeat (10) applyStimulus();
    checkOutput("glitch_leds", 42'(leds), 42'(3'b000));

    // Reset while running.
    playBtn = 1'b0;
    waitLeds(3'b001, 40, "rst_run");
    playBtn = 1'b1;
    repeat (37) applyStimulus();
    reset = 1'b0;
    applyStimulus();
    checkOutput("midrst_leds", 42'(leds), 42'(3'b000));
    checkOutput("midrst_disp", obsDisp, {6{s0}});
    reset = 1'b1;
    repeat (10) applyStimulus();

    // Random mix of presses, glitches, pause toggles, mode changes and waits.
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 5))
        0: begin
          playBtn = 1'b0;
          repeat ($urandom_range(1, 6)) applyStimulus();
          playBtn = 1'b1;
          repeat (6) applyStimulus();
        end
        1: begin
          switchPause = ~switchPause;
          applyStimulus();
        end
        2: begin
          n = $urandom_range(0, 2);
          if (n == 2) n = 2 + $urandom_range(0, 1);
          {switchMode1, switchMode0} = 2'(n);
          applyStimulus();
        end
        default: repeat ($urandom_range(1, 150)) applyStimulus();
      endcase
    end
    repeat (5) applyStimulus();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cronometro_ctrl.md
CRONOMETRO_CTRL -- requirements
Module: cronometro_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 500000, clk cycles per 10 ms tick (50 MHz clk).
REQ-002 Parameter DEB_CYCLES, default 500000, cycles play_btn must be stable before a change is accepted.
REQ-003 Parameter PRESET_MIN, default 1, countdown start value in minutes, range 0..59.
REQ-004 clk  in  1  sole clock, all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 switch_mode0, switch_mode1  in  1 each  mode select {mode1,mode0}: 00 count-up, 01 countdown, 1x clear.
REQ-007 switch_pause  in  1  level; 1 requests hold.
REQ-008 play_btn  in  1  push button, active-low (0 = pressed).
REQ-009 disp0..disp5  out  7 each  active-low segments {g..a}: disp5/disp4 minutes tens/units, disp3/disp2 seconds, disp1/disp0 centiseconds.
REQ-010 leds  out  3  leds[0] RUN, leds[1] PAUSE, leds[2] DONE; all 0 in IDLE.

Function
REQ-011 All async inputs shall pass a 2-FF synchronizer; play_btn shall then be debounced, and a press event is a single-cycle strobe on the debounced released-to-pressed transition.
REQ-012 Time shall be held as 6 BCD digits MM:SS.cc, digit ranges 0-5/0-9/0-5/0-9/0-9/0-9.
REQ-013 Prescaler counts 0..TICK_DIV-1 only in RUN, strobes tick at TICK_DIV-1, holds value in PAUSE, clears in IDLE/DONE.
REQ-014 States: IDLE, RUN, PAUSE, DONE.
REQ-015 IDLE: count loaded with 00:00.00 (mode 00 or 1x) or PRESET_MIN:00.00 (mode 01); press and mode != 1x -> RUN.
REQ-016 RUN: each tick adds 1 cc (mode 00) or subtracts 1 cc (mode 01) with BCD carry/borrow across all digits; count updates on the cycle after the tick strobe.
REQ-017 RUN: switch_pause=1 or press -> PAUSE; a tick in the same cycle is discarded.
REQ-018 Count-up at 59:59.99 + tick shall wrap to 00:00.00 and stay in RUN.
REQ-019 Countdown reaching 00:00.00 -> DONE; PRESET_MIN=0 with press from IDLE -> DONE directly.
REQ-020 PAUSE: count frozen; press with switch_pause=0 -> RUN; press with switch_pause=1 ignored.
REQ-021 DONE: count held at 00:00.00; press -> IDLE with reload.
REQ-022 Synchronized mode value differing from its registered copy shall, in any state, force IDLE with reload next cycle, overriding press, pause and tick.
REQ-023 disp* and leds shall be registered, reflecting count/state with 1 cycle latency.

Reset
REQ-024 reset=0 at a clk edge: state IDLE, count 00:00.00, prescaler 0, debouncer released, mode copy 00, leds 000, all disp encode "0" (7'b1000000).
REQ-025 Reset mid-RUN shall take effect on the next edge, discarding any pending tick or press.

Structure
REQ-026 Package cronometro_pkg shall hold the state enum, mode enum, BCD digit type and 7-segment constants.
REQ-027 Sub-module seg7_decoder (BCD -> active-low 7-seg, non-BCD blank 7'h7F) shall be instantiated six times.

Verification (TICK_DIV=4, DEB_CYCLES=2, PRESET_MIN=1)
REQ-028 Reset, mode 00, press, 400 cycles -> count 00:01.00, leds 001, disp2 "1".
REQ-029 Count-up preload 59:59.98 via force, 2 ticks -> 00:00.00, state RUN.
REQ-030 Mode 01, press, 24000 cycles -> 00:00.00, leds 100; press -> IDLE, count 01:00.00.
REQ-031 RUN, switch_pause=1 for 40 cycles -> count unchanged, leds 010; release + press -> counting resumes.
REQ-032 Mode switch 00->01 during RUN coinciding with tick -> next cycle IDLE, count 01:00.00.
REQ-033 play_btn glitch of 1 cycle -> no press event, state unchanged.
